decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/y86_pkg.sv | 35 +++
 rtl/y86_regfile.sv | 43 ++++
 rtl/decode_stage.sv | 151 +++++++++++++++
 tb/tb_decode_stage.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: instruction codes, register IDs, status codes,
// and a helper that tests whether a forwarding source applies to a read.
package y86_pkg;

  typedef enum logic [3:0] {
    I_HALT   = 4'h0,
    I_NOP    = 4'h1,
    I_RRMOVQ = 4'h2,
    I_IRMOVQ = 4'h3,
    I_RMMOVQ = 4'h4,
    I_MRMOVQ = 4'h5,
    I_OPQ    = 4'h6,
    I_JXX    = 4'h7,
    I_CALL   = 4'h8,
    I_RET    = 4'h9,
    I_PUSHQ  = 4'hA,
    I_POPQ   = 4'hB
  } icode_e;

  typedef enum logic [1:0] {
    STAT_AOK = 2'd0,
    STAT_HLT = 2'd1,
    STAT_ADR = 2'd2,
    STAT_INS = 2'd3
  } stat_e;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  // A forward source applies only when both IDs name a real register.
  function automatic logic fwd_hit(input logic [3:0] src, input logic [3:0] dst);
    return (src != RNONE) && (src == dst);
  endfunction

endpackage

// File: rtl/y86_regfile.sv
// Y86-64 register file: 15 x 64-bit registers (IDs 0-14); ID F reads 0 and
// is never written.
//   clk, rst_n        : clock, synchronous active-low reset
//   src_a/src_b       : combinational read IDs -> val_a/val_b
//   dst_e/val_e       : write port E
//   dst_m/val_m       : write port M (wins over E on equal IDs)
// Reset clears every register except %rsp, which loads RSP_RESET; no writes
// take effect in a reset cycle.
module y86_regfile
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  src_a,
  input  logic [3:0]  src_b,
  output logic [63:0] val_a,
  output logic [63:0] val_b,
  input  logic [3:0]  dst_e,
  input  logic [63:0] val_e,
  input  logic [3:0]  dst_m,
  input  logic [63:0] val_m
);

  logic [63:0] regs [15];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < 15; i++) begin
        regs[i] <= (i == 32'(RSP)) ? RSP_RESET : '0;
      end
    end else begin
      if (dst_e != RNONE) regs[dst_e] <= val_e;
      // Later assignment takes effect: M port has priority on equal IDs.
      if (dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  assign val_a = (src_a == RNONE) ? '0 : regs[src_a];
  assign val_b = (src_b == RNONE) ? '0 : regs[src_b];

endmodule

// File: rtl/decode_stage.sv
// Y86-64 pipeline decode stage with writeback into the register file and the
// execute pipeline register.
//   clk, rst_n                     : clock, synchronous active-low reset
//   D_icode/ifun/rA/rB/valC/valP   : decode register fields
//   D_stat                         : status, propagated to E_stat
//   E_bubble                       : load a nop into the execute register
//   e_dstE/e_valE, M_dstE/M_valE, M_dstM/m_valM, W_dstE/W_valE,
//   W_dstM/W_valM                  : forward sources (W pairs also write)
//   d_srcA/d_srcB                  : combinational source IDs for hazard control
//   E_*                            : execute pipeline register outputs
// Macro DECODE_FWD_EN: when defined, valA/valB use the forwarding chain;
// otherwise they come from D_valP or the register file only and upstream
// control must stall on every data hazard.
module decode_stage
  import y86_pkg::*;
#(
  parameter logic [63:0] RSP_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  D_icode,
  input  logic [3:0]  D_ifun,
  input  logic [3:0]  D_rA,
  input  logic [3:0]  D_rB,
  input  logic [63:0] D_valC,
  input  logic [63:0] D_valP,
  input  logic [1:0]  D_stat,
  input  logic        E_bubble,
  input  logic [3:0]  e_dstE,
  input  logic [63:0] e_valE,
  input  logic [3:0]  M_dstE,
  input  logic [63:0] M_valE,
  input  logic [3:0]  M_dstM,
  input  logic [63:0] m_valM,
  input  logic [3:0]  W_dstE,
  input  logic [63:0] W_valE,
  input  logic [3:0]  W_dstM,
  input  logic [63:0] W_valM,
  output logic [3:0]  d_srcA,
  output logic [3:0]  d_srcB,
  output logic [3:0]  E_icode,
  output logic [3:0]  E_ifun,
  output logic [3:0]  E_dstE,
  output logic [3:0]  E_dstM,
  output logic [63:0] E_valC,
  output logic [63:0] E_valA,
  output logic [63:0] E_valB,
  output logic [1:0]  E_stat
);

  logic [3:0]  d_dstE, d_dstM;
  logic [63:0] rf_val_a, rf_val_b;
  logic [63:0] d_valA, d_valB;

  y86_regfile #(
    .RSP_RESET (RSP_RESET)
  ) u_regfile (
    .clk   (clk),
    .rst_n (rst_n),
    .src_a (d_srcA),
    .src_b (d_srcB),
    .val_a (rf_val_a),
    .val_b (rf_val_b),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM)
  );

  // Register ID selection by instruction class.
  always_comb begin
    d_srcA = RNONE;
    d_srcB = RNONE;
    d_dstE = RNONE;
    d_dstM = RNONE;

    case (D_icode)
      I_RRMOVQ, I_RMMOVQ, I_OPQ, I_PUSHQ: d_srcA = D_rA;
      I_RET, I_POPQ:                      d_srcA = RSP;
      default:                            d_srcA = RNONE;
    endcase

    case (D_icode)
      I_RMMOVQ, I_MRMOVQ, I_OPQ:          d_srcB = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_srcB = RSP;
      default:                            d_srcB = RNONE;
    endcase

    case (D_icode)
      I_RRMOVQ, I_IRMOVQ, I_OPQ:          d_dstE = D_rB;
      I_CALL, I_RET, I_PUSHQ, I_POPQ:     d_dstE = RSP;
      default:                            d_dstE = RNONE;
    endcase

    case (D_icode)
      I_MRMOVQ, I_POPQ:                   d_dstM = D_rA;
      default:                            d_dstM = RNONE;
    endcase
  end

  // Operand selection: nearest pipeline stage first.
  always_comb begin
    d_valA = rf_val_a;
    if (D_icode == I_CALL || D_icode == I_JXX) d_valA = D_valP;
`ifdef DECODE_FWD_EN
    else if (fwd_hit(d_srcA, e_dstE)) d_valA = e_valE;
    else if (fwd_hit(d_srcA, M_dstM)) d_valA = m_valM;
    else if (fwd_hit(d_srcA, M_dstE)) d_valA = M_valE;
    else if (fwd_hit(d_srcA, W_dstM)) d_valA = W_valM;
    else if (fwd_hit(d_srcA, W_dstE)) d_valA = W_valE;
`endif
  end

  always_comb begin
    d_valB = rf_val_b;
`ifdef DECODE_FWD_EN
    if      (fwd_hit(d_srcB, e_dstE)) d_valB = e_valE;
    else if (fwd_hit(d_srcB, M_dstM)) d_valB = m_valM;
    else if (fwd_hit(d_srcB, M_dstE)) d_valB = M_valE;
    else if (fwd_hit(d_srcB, W_dstM)) d_valB = W_valM;
    else if (fwd_hit(d_srcB, W_dstE)) d_valB = W_valE;
`else
    // Forward sources are unused in this build.
    if (1'b0 && (|{e_dstE, e_valE, M_dstE, M_valE, M_dstM, m_valM})) d_valB = '0;
`endif
  end

  // Execute pipeline register; reset and bubble both load a nop.
  always_ff @(posedge clk) begin
    if (!rst_n || E_bubble) begin
      E_icode <= I_NOP;
      E_ifun  <= '0;
      E_dstE  <= RNONE;
      E_dstM  <= RNONE;
      E_valC  <= '0;
      E_valA  <= '0;
      E_valB  <= '0;
      E_stat  <= STAT_AOK;
    end else begin
      E_icode <= D_icode;
      E_ifun  <= D_ifun;
      E_dstE  <= d_dstE;
      E_dstM  <= d_dstM;
      E_valC  <= D_valC;
      E_valA  <= d_valA;
      E_valB  <= d_valB;
      E_stat  <= D_stat;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [3:0]  D_icode, D_ifun, D_rA, D_rB;
  logic [63:0] D_valC, D_valP;
  logic [1:0]  D_stat;
  logic        E_bubble;
  logic [3:0]  e_dstE, M_dstE, M_dstM, W_dstE, W_dstM;
  logic [63:0] e_valE, M_valE, m_valM, W_valE, W_valM;
  logic [3:0]  d_srcA, d_srcB;
  logic [3:0]  E_icode, E_ifun, E_dstE, E_dstM;
  logic [63:0] E_valC, E_valA, E_valB;
  logic [1:0]  E_stat;

  decode_stage #(
    .RSP_RESET (64'h100)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .D_icode  (D_icode),
    .D_ifun   (D_ifun),
    .D_rA     (D_rA),
    .D_rB     (D_rB),
    .D_valC   (D_valC),
    .D_valP   (D_valP),
    .D_stat   (D_stat),
    .E_bubble (E_bubble),
    .e_dstE   (e_dstE),
    .e_valE   (e_valE),
    .M_dstE   (M_dstE),
    .M_valE   (M_valE),
    .M_dstM   (M_dstM),
    .m_valM   (m_valM),
    .W_dstE   (W_dstE),
    .W_valE   (W_valE),
    .W_dstM   (W_dstM),
    .W_valM   (W_valM),
    .d_srcA   (d_srcA),
    .d_srcB   (d_srcB),
    .E_icode  (E_icode),
    .E_ifun   (E_ifun),
    .E_dstE   (E_dstE),
    .E_dstM   (E_dstM),
    .E_valC   (E_valC),
    .E_valA   (E_valA),
    .E_valB   (E_valB),
    .E_stat   (E_stat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  dste;
    logic [3:0]  dstm;
    logic [63:0] vala;
    logic [63:0] valb;
    logic [63:0] valc;
    logic [1:0]  stat;
  } exp_t;

  exp_t sb[$];
  int   n_asserts = 0;
  int   n_fail = 0;

`ifdef DECODE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_d(input logic [3:0] icode, input logic [3:0] ifun,
                       input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] valc, input logic [63:0] valp,
                       input logic [1:0] stat);
    D_icode = icode; D_ifun = ifun; D_rA = ra; D_rB = rb;
    D_valC = valc; D_valP = valp; D_stat = stat;
  endtask

  task automatic clr_side();
    e_dstE = 4'hF; e_valE = '0;
    M_dstE = 4'hF; M_valE = '0;
    M_dstM = 4'hF; m_valM = '0;
    W_dstE = 4'hF; W_valE = '0;
    W_dstM = 4'hF; W_valM = '0;
  endtask

  task automatic push(input string tag, input logic [3:0] icode, input logic [3:0] ifun,
                      input logic [3:0] dste, input logic [3:0] dstm,
                      input logic [63:0] vala, input logic [63:0] valb,
                      input logic [63:0] valc, input logic [1:0] stat);
    exp_t e;
    e.tag = tag; e.icode = icode; e.ifun = ifun; e.dste = dste; e.dstm = dstm;
    e.vala = vala; e.valb = valb; e.valc = valc; e.stat = stat;
    sb.push_back(e);
  endtask

  task automatic tick_check();
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = sb.pop_front();
      check({e.tag, ".icode"}, 64'(E_icode), 64'(e.icode));
      check({e.tag, ".ifun"},  64'(E_ifun),  64'(e.ifun));
      check({e.tag, ".dstE"},  64'(E_dstE),  64'(e.dste));
      check({e.tag, ".dstM"},  64'(E_dstM),  64'(e.dstm));
      check({e.tag, ".valA"},  E_valA,       e.vala);
      check({e.tag, ".valB"},  E_valB,       e.valb);
      check({e.tag, ".valC"},  E_valC,       e.valc);
      check({e.tag, ".stat"},  64'(E_stat),  64'(e.stat));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    E_bubble = 1'b0;
    clr_side();
    set_d(4'h1, 4'h0, 4'hF, 4'hF, '0, '0, 2'd0);
    @(negedge clk);

    // Reset; a concurrent W write to reg 0 must be ignored.
    W_dstE = 4'h0; W_valE = 64'h55;
    set_d(4'h2, 4'h0, 4'h4, 4'h0, '0, '0, 2'd0);
    push("reset", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    rst_n = 1'b1;
    clr_side();
    set_d(4'h2, 4'h0, 4'h4, 4'h0, 64'h11, '0, 2'd0);
    #1;
    check("rrmovq.srcA", 64'(d_srcA), 64'h4);
    check("rrmovq.srcB", 64'(d_srcB), 64'hF);
    push("rsp_read", 4'h2, 4'h0, 4'h0, 4'hF, 64'h100, 64'h0, 64'h11, 2'd0);
    tick_check();

    W_dstE = 4'h2; W_valE = 64'h5;
    set_d(4'h2, 4'h0, 4'h0, 4'h1, '0, '0, 2'd0);
    push("r0_read", 4'h2, 4'h0, 4'h1, 4'hF, 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    clr_side();
    set_d(4'h6, 4'h0, 4'h2, 4'h3, '0, '0, 2'd0);
    #1;
    check("addq.srcA", 64'(d_srcA), 64'h2);
    check("addq.srcB", 64'(d_srcB), 64'h3);
    push("wb_addq", 4'h6, 4'h0, 4'h3, 4'hF, 64'h5, 64'h0, 64'h0, 2'd0);
    tick_check();

    // Execute-stage forward must beat the writeback of the same register.
    e_dstE = 4'h3; e_valE = 64'h7;
    W_dstE = 4'h3; W_valE = 64'h9;
    set_d(4'h2, 4'h0, 4'h3, 4'h5, '0, '0, 2'd0);
    push("fwd_prio", 4'h2, 4'h0, 4'h5, 4'hF, FWD ? 64'h7 : 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    clr_side();
    set_d(4'h2, 4'h0, 4'h3, 4'h6, '0, '0, 2'd0);
    push("wb_r3", 4'h2, 4'h0, 4'h6, 4'hF, 64'h9, 64'h0, 64'h0, 2'd0);
    tick_check();

    // popq %rsp writeback: M port wins.
    W_dstE = 4'h4; W_valE = 64'h8;
    W_dstM = 4'h4; W_valM = 64'hA;
    set_d(4'h1, 4'h0, 4'hF, 4'hF, '0, '0, 2'd0);
    push("nop", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    clr_side();
    set_d(4'hA, 4'h0, 4'h7, 4'hF, '0, '0, 2'd0);
    #1;
    check("pushq.srcB", 64'(d_srcB), 64'h4);
    push("pushq_rsp", 4'hA, 4'h0, 4'h4, 4'hF, 64'h0, 64'hA, 64'h0, 2'd0);
    tick_check();

    set_d(4'h8, 4'h0, 4'hF, 4'hF, 64'h1234, 64'h2A, 2'd2);
    #1;
    check("call.srcA", 64'(d_srcA), 64'hF);
    check("call.srcB", 64'(d_srcB), 64'h4);
    push("call", 4'h8, 4'h0, 4'h4, 4'hF, 64'h2A, 64'hA, 64'h1234, 2'd2);
    tick_check();

    E_bubble = 1'b1;
    set_d(4'h3, 4'h0, 4'hF, 4'h2, 64'h99, '0, 2'd1);
    push("bubble", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    E_bubble = 1'b0;
    set_d(4'h5, 4'h3, 4'h8, 4'h2, 64'h10, '0, 2'd3);
    push("mrmovq", 4'h5, 4'h3, 4'hF, 4'h8, 64'h0, 64'h5, 64'h10, 2'd3);
    tick_check();

    // Memory-stage sources: m_valM beats M_valE; W_valE forwards to srcA.
    M_dstM = 4'h2; m_valM = 64'h33;
    M_dstE = 4'h2; M_valE = 64'h44;
    W_dstE = 4'h1; W_valE = 64'h77;
    set_d(4'h6, 4'h1, 4'h1, 4'h2, '0, '0, 2'd0);
    push("fwd_mem", 4'h6, 4'h1, 4'h2, 4'hF,
         FWD ? 64'h77 : 64'h0, FWD ? 64'h33 : 64'h5, 64'h0, 2'd0);
    tick_check();

    // Reset mid-operation: bubble loaded, W write to reg 5 suppressed.
    clr_side();
    rst_n = 1'b0;
    W_dstE = 4'h5; W_valE = 64'hEE;
    set_d(4'h6, 4'h0, 4'h1, 4'h2, '0, '0, 2'd0);
    push("mid_reset", 4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    rst_n = 1'b1;
    clr_side();
    set_d(4'h6, 4'h0, 4'h4, 4'h5, '0, '0, 2'd0);
    push("post_reset", 4'h6, 4'h0, 4'h5, 4'hF, 64'h100, 64'h0, 64'h0, 2'd0);
    tick_check();

    set_d(4'hB, 4'h0, 4'h1, 4'hF, '0, '0, 2'd0);
    #1;
    check("popq.srcA", 64'(d_srcA), 64'h4);
    push("popq", 4'hB, 4'h0, 4'h4, 4'h1, 64'h100, 64'h100, 64'h0, 2'd0);
    tick_check();

    set_d(4'h2, 4'h0, 4'h1, 4'h2, '0, '0, 2'd0);
    push("r1_cleared", 4'h2, 4'h0, 4'h2, 4'hF, 64'h0, 64'h0, 64'h0, 2'd0);
    tick_check();

    check("scoreboard_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
